alu_multicycle: RTL and testbench

Parametrised, registered ALU for the next-generation datapath. It keeps the four single-cycle operations of the current 8-bit ALU: forward, add, and, or. It fills the four reserved opcodes with iterative operations: multiply, logical shift left, arithmetic shift right and rotate right. A START/BUSY/DONE handshake lets the control unit stall while an operation runs. Operands are latched on acceptance; RESULT and ZERO are registered and held until the next completion.

---
 rtl/alu_multicycle.sv | 123 ++++++++++++
 tb/tb_alu_multicycle.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with single-cycle and iterative ops behind a START/BUSY/DONE handshake.
// Define ALU_MUL_EN to build the shift-add multiplier on opcode 100; otherwise it returns 0.
module alu_multicycle #(
    parameter int WIDTH = 8,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO
);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] step;
    logic [2:0]       op;
    logic [SHW:0]     cnt;
    logic [SHW:0]     cnt_init;
    logic [SHW-1:0]   n;
    logic             shift_en;

    assign n        = DATA2[SHW-1:0];
    assign shift_en = (b[SHW-1:0] != '0);
    assign BUSY     = (state == RUN);

    always_comb begin
        cnt_init = CNT_ONE;
        case (SELECT)
`ifdef ALU_MUL_EN
            OP_MUL: cnt_init = (SHW+1)'(WIDTH);
`endif
            OP_SLL, OP_SRA, OP_ROR: begin
                if (n != '0) cnt_init = {1'b0, n};
            end
            default: cnt_init = CNT_ONE;
        endcase
    end

    // A shift by zero still spends one RUN cycle but leaves acc untouched.
    always_comb begin
        step = '0;
        case (op)
            OP_FWD: step = b;
            OP_ADD: step = a + b;
            OP_AND: step = a & b;
            OP_OR:  step = a | b;
`ifdef ALU_MUL_EN
            OP_MUL: step = b[0] ? acc + a : acc;
`endif
            OP_SLL: step = shift_en ? {acc[WIDTH-2:0], 1'b0} : acc;
            OP_SRA: step = shift_en ? {acc[WIDTH-1], acc[WIDTH-1:1]} : acc;
            OP_ROR: step = shift_en ? {acc[0], acc[WIDTH-1:1]} : acc;
            default: step = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            DONE   <= 1'b0;
            RESULT <= '0;
            ZERO   <= 1'b1;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            op     <= OP_FWD;
            cnt    <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        a     <= DATA1;
                        b     <= DATA2;
                        op    <= SELECT;
                        acc   <= (SELECT == OP_MUL) ? '0 : DATA1;
                        cnt   <= cnt_init;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= step;
                    cnt <= cnt - CNT_ONE;
`ifdef ALU_MUL_EN
                    if (op == OP_MUL) begin
                        a <= a << 1;
                        b <= b >> 1;
                    end
`endif
                    if (cnt == CNT_ONE) begin
                        RESULT <= step;
                        ZERO   <= (step == '0);
                        DONE   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=8).
// Stimulus pushes expected results; a negedge monitor pops them on DONE.
module tb_alu_multicycle;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef struct {
        logic [7:0] res;
        logic       z;
        int         done_cyc;
        int         lat;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;

    int   checks;
    int   errors;
    int   cyc;
    int   busyc;
    exp_t sb[$];

    alu_multicycle #(.WIDTH(8)) dut (
        .CLK(clk),
        .RESET(rst_n),
        .START(start),
        .DATA1(data1),
        .DATA2(data2),
        .SELECT(sel),
        .BUSY(busy),
        .DONE(done),
        .RESULT(result),
        .ZERO(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) busyc = 0;
        else if (busy) busyc++;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, int'(result), int'(e.res));
                chk({e.name, "_zero"}, int'(zero), int'(e.z));
                chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
                chk({e.name, "_busy_cycles"}, busyc, e.lat - 1);
            end
            busyc = 0;
        end
    end

    // nowait: drive in the current negedge (used to hit the DONE cycle).
    task automatic issue(input logic [2:0] op, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] res,
                         input int lat, input bit push, input bit nowait,
                         input string nm);
        if (!nowait) @(negedge clk);
        sel   = op;
        data1 = d1;
        data2 = d2;
        start = 1'b1;
        if (push) sb.push_back('{res, (res == 8'h00), cyc + lat, lat, nm});
        @(negedge clk);
        start = 1'b0;
        data1 = 8'($urandom);
        data2 = 8'($urandom);
        sel   = 3'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", int'(done), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        busyc  = 0;
        rst_n  = 1'b0;
        start  = 1'b1;
        sel    = OP_ADD;
        data1  = 8'h12;
        data2  = 8'h34;

        // Reset held 2 cycles with START=1
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_zero", int'(zero), 1);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle_busy", int'(busy), 0);

        issue(OP_ADD, 8'hF0, 8'h10, 8'h00, 2, 1, 0, "add_wrap");
        drain();
        issue(OP_FWD, 8'h00, 8'h5A, 8'h5A, 2, 1, 0, "fwd");
        drain();
        issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 2, 1, 0, "and");
        drain();
        issue(OP_OR, 8'hF0, 8'h0C, 8'hFC, 2, 1, 0, "or");
        drain();
`ifdef ALU_MUL_EN
        issue(OP_MUL, 8'h0D, 8'h0B, 8'h8F, 9, 1, 0, "mul_0d_0b");
        drain();
        issue(OP_MUL, 8'h10, 8'h10, 8'h00, 9, 1, 0, "mul_ovf");
        drain();
`else
        issue(OP_MUL, 8'h0D, 8'h0B, 8'h00, 2, 1, 0, "mul_off");
        drain();
`endif
        issue(OP_SRA, 8'h96, 8'h03, 8'hF2, 4, 1, 0, "sra3");
        drain();
        issue(OP_ROR, 8'h96, 8'h0B, 8'hD2, 4, 1, 0, "ror3");
        drain();
        issue(OP_SLL, 8'h96, 8'h00, 8'h96, 2, 1, 0, "sll0");
        drain();
        issue(OP_SLL, 8'h96, 8'h02, 8'h58, 3, 1, 0, "sll2");
        drain();
        issue(OP_SLL, 8'h01, 8'h07, 8'h80, 8, 1, 0, "sll7");
        drain();
        issue(OP_SRA, 8'h96, 8'h08, 8'h96, 2, 1, 0, "sra_n0_hi");
        drain();

        // START while BUSY must be ignored
`ifdef ALU_MUL_EN
        issue(OP_MUL, 8'h07, 8'h06, 8'h2A, 9, 1, 0, "mul_ignore");
`else
        issue(OP_ROR, 8'h96, 8'h05, 8'hB4, 6, 1, 0, "ror_ignore");
`endif
        @(negedge clk);
        sel   = OP_FWD;
        data2 = 8'h77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // Back-to-back: START in the DONE cycle
        issue(OP_ADD, 8'h01, 8'h02, 8'h03, 2, 1, 0, "b2b_first");
        wait_done();
        issue(OP_OR, 8'h40, 8'h01, 8'h41, 2, 1, 1, "b2b_second");
        chk("b2b_busy", int'(busy), 1);
        drain();

        issue(OP_FWD, 8'h00, 8'h5A, 8'h5A, 2, 1, 0, "pre_abort");
        drain();

        // Abort in RUN cycle 4
`ifdef ALU_MUL_EN
        issue(OP_MUL, 8'h0D, 8'h0B, 8'h00, 9, 0, 0, "abort");
`else
        issue(OP_ROR, 8'h96, 8'h07, 8'h00, 8, 0, 0, "abort");
`endif
        repeat (3) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_zero", int'(zero), 1);
        repeat (10) @(negedge clk);
        chk("abort_result_hold", int'(result), 0);

        issue(OP_ADD, 8'h22, 8'h11, 8'h33, 2, 1, 0, "post_abort");
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
